mem_port_unit: RTL

- Sits between the multicycle controller and the external unified instruction/data memory.
- Turns the controller's ir_write / i_or_d / mem_write strobes into request/acknowledge bus transactions.
- Holds the instruction register (IR) and the memory data register (MDR), and drives the decoded op/funct fields back to the controller.
- Drives stall while a transaction is outstanding; the controller holds its state while stall=1.

---
 rtl/mem_port_unit_pkg.sv | 35 +++
 rtl/mem_port_unit_if.sv | 22 ++
 rtl/mem_port_unit_instr_decode.sv | 23 ++
 rtl/mem_port_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_port_unit_pkg.sv
// Shared types and constants for the memory port unit and the multicycle controller.
package mem_port_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } kind_e;

    // Instruction field positions (MIPS-style encoding)
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = 16;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

endpackage

// File: rtl/mem_port_unit_if.sv
// Request/acknowledge bus between the memory port unit and the unified memory.
interface mem_port_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_unit_instr_decode.sv
// Combinational IR-to-field splitter, shared with the datapath.
module mem_port_unit_instr_decode
    import mem_port_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]  instr,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   shamt,
    output logic [FUNCT_W-1:0] funct,
    output logic [IMM_W-1:0]   imm
);
    assign op    = instr[OP_LSB    +: OP_W];
    assign rs    = instr[RS_LSB    +: REG_W];
    assign rt    = instr[RT_LSB    +: REG_W];
    assign rd    = instr[RD_LSB    +: REG_W];
    assign shamt = instr[SHAMT_LSB +: REG_W];
    assign funct = instr[FUNCT_LSB +: FUNCT_W];
    assign imm   = instr[IMM_LSB   +: IMM_W];
endmodule

// File: rtl/mem_port_unit.sv
// Converts controller fetch/load/store strobes into bus transactions and
// holds IR/MDR; stalls the controller while a transaction is outstanding.
module mem_port_unit
    import mem_port_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               i_or_d,
    input  logic               ir_write,
    input  logic               mem_write,
    mem_port_unit_if.master    bus,
    output logic               stall,
    output logic [DATA_W-1:0]  instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [15:0]        imm,
    output logic [DATA_W-1:0]  mdr,
    output logic               err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    kind_e              kind_q, kind_d, kind_sel;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr_sel;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trig;

    assign trig     = ir_write | mem_write | i_or_d;
    assign addr_sel = i_or_d ? alu_out : pc;

    // ir_write wins over mem_write; i_or_d alone means a load
    always_comb begin
        kind_sel = KIND_LOAD;
        if (ir_write)       kind_sel = KIND_FETCH;
        else if (mem_write) kind_sel = KIND_STORE;
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = trig & rstb;
                if (trig) begin
                    kind_d  = kind_sel;
                    we_d    = (kind_sel == KIND_STORE);
                    addr_d  = addr_sel;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (addr_sel[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.mem_ack) begin
                    case (kind_q)
                        KIND_FETCH: ir_d  = bus.mem_rdata;
                        KIND_LOAD:  mdr_d = bus.mem_rdata;
                        default:    ;
                    endcase
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Strobes seen here are the stale ones from the finished access
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_FETCH;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign instr         = ir_q;
    assign mdr           = mdr_q;
    assign err           = err_q;

    mem_port_unit_instr_decode #(.DATA_W(DATA_W)) u_decode (
        .instr (ir_q),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .shamt (shamt),
        .funct (funct),
        .imm   (imm)
    );
endmodule
